// File: rtl/sbh_cost_select.sv
// Group-level sign-bit-hiding cost selector: per-lane change cost, lane and beat
// reduction, one minimum-cost result per coefficient group. Optional macro SBH_CLAMP_MAX_EN.
module sbh_cost_select #(
    parameter int COEFF_W = 16,
    parameter int LANES   = 4,
    parameter int CG_SIZE = 16,
    parameter int COST_W  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_last,
    input  logic [LANES*COEFF_W-1:0]     coef_in,
    input  logic [LANES*COEFF_W-1:0]     deltaU_in,
    input  logic [LANES-1:0]             first_nz_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [COST_W-1:0]            best_cost,
    output logic [1:0]                   best_change,
    output logic [$clog2(CG_SIZE)-1:0]   best_pos,
    output logic                         found,
    output logic                         grp_err
);

    localparam int BEATS = CG_SIZE / LANES;
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int POS_W = $clog2(CG_SIZE);
    localparam logic [COST_W-1:0]  INV     = {1'b0, {(COST_W-1){1'b1}}};
    localparam logic [COEFF_W-1:0] MAG_MAX = {1'b0, {(COEFF_W-1){1'b1}}};
    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_INC  = 2'b01;
    localparam logic [1:0] CHG_DEC  = 2'b11;

    logic                          w_en;
    logic                          w_accept;
    logic                          w_close;
    logic [LANES-1:0][COST_W-1:0]  w_cost;
    logic [LANES-1:0][1:0]         w_chg;

    logic [BCW-1:0]                r_beat_cnt;
    logic                          r_s1_valid;
    logic [LANES-1:0][COST_W-1:0]  r_s1_cost;
    logic [LANES-1:0][1:0]         r_s1_chg;
    logic [BCW-1:0]                r_s1_beat;
    logic                          r_s1_close;
    logic                          r_s1_err;

    logic [COST_W-1:0]             r_acc_cost;
    logic [1:0]                    r_acc_chg;
    logic [POS_W-1:0]              r_acc_pos;

    logic                          r_out_valid;
    logic [COST_W-1:0]             r_best_cost;
    logic [1:0]                    r_best_chg;
    logic [POS_W-1:0]              r_best_pos;
    logic                          r_found;
    logic                          r_grp_err;

    // The whole pipeline stalls behind an unaccepted result.
    assign w_en     = !r_out_valid || out_ready;
    assign w_accept = in_valid && w_en;
    assign w_close  = in_last || (r_beat_cnt == BCW'(BEATS - 1));

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [COEFF_W-1:0] w_c;
        logic signed [COEFF_W-1:0] w_d;
        logic        [COEFF_W-1:0] w_mag;
        logic signed [COST_W-1:0]  w_dx;
        logic signed [COST_W-1:0]  w_lcost;
        logic        [1:0]         w_lchg;

        assign w_c   = coef_in[g*COEFF_W +: COEFF_W];
        assign w_d   = deltaU_in[g*COEFF_W +: COEFF_W];
        assign w_mag = w_c[COEFF_W-1] ? -w_c : w_c;
        assign w_dx  = COST_W'(w_d);

        always_comb begin
            w_lcost = INV;
            w_lchg  = CHG_NONE;
            if (w_dx > 0) begin
                w_lcost = -w_dx;
                w_lchg  = CHG_INC;
            end else if (w_dx < 0 && w_mag != '0 &&
                         !(first_nz_in[g] && w_mag == COEFF_W'(1))) begin
                w_lcost = w_dx;
                w_lchg  = CHG_DEC;
            end
`ifdef SBH_CLAMP_MAX_EN
            if (w_lchg == CHG_INC && w_mag == MAG_MAX) begin
                w_lcost = INV;
                w_lchg  = CHG_NONE;
            end
`endif
        end

        assign w_cost[g] = w_lcost;
        assign w_chg[g]  = w_lchg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= w_close ? '0 : r_beat_cnt + BCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_cost  <= '0;
            r_s1_chg   <= '0;
            r_s1_beat  <= '0;
            r_s1_close <= 1'b0;
            r_s1_err   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_cost  <= w_cost;
                r_s1_chg   <= w_chg;
                r_s1_beat  <= r_beat_cnt;
                r_s1_close <= w_close;
                r_s1_err   <= w_close && !in_last;
            end
        end
    end

    logic [COST_W-1:0] w_bm_cost;
    logic [1:0]        w_bm_chg;
    logic [LW-1:0]     w_bm_lane;
    logic [POS_W-1:0]  w_bm_pos;
    logic              w_take;
    logic [COST_W-1:0] w_n_cost;
    logic [1:0]        w_n_chg;
    logic [POS_W-1:0]  w_n_pos;
    logic              w_adv;
    logic              w_n_found;

    // Strict compare keeps the lowest lane on ties.
    always_comb begin
        w_bm_cost = r_s1_cost[0];
        w_bm_chg  = r_s1_chg[0];
        w_bm_lane = '0;
        for (int i = 1; i < LANES; i++) begin
            if ($signed(r_s1_cost[i]) < $signed(w_bm_cost)) begin
                w_bm_cost = r_s1_cost[i];
                w_bm_chg  = r_s1_chg[i];
                w_bm_lane = LW'(i);
            end
        end
    end

    assign w_bm_pos  = POS_W'(r_s1_beat) * POS_W'(LANES) + POS_W'(w_bm_lane);
    assign w_take    = (r_s1_beat == '0) || ($signed(w_bm_cost) < $signed(r_acc_cost));
    assign w_n_cost  = w_take ? w_bm_cost : r_acc_cost;
    assign w_n_chg   = w_take ? w_bm_chg  : r_acc_chg;
    assign w_n_pos   = w_take ? w_bm_pos  : r_acc_pos;
    assign w_n_found = (w_n_cost != INV);
    assign w_adv     = w_en && r_s1_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cost <= INV;
            r_acc_chg  <= CHG_NONE;
            r_acc_pos  <= '0;
        end else if (w_adv) begin
            r_acc_cost <= w_n_cost;
            r_acc_chg  <= w_n_chg;
            r_acc_pos  <= w_n_pos;
        end
    end

    // Result register loads on the closing beat's reduction; no-change results are normalised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_best_cost <= INV;
            r_best_chg  <= CHG_NONE;
            r_best_pos  <= '0;
            r_found     <= 1'b0;
            r_grp_err   <= 1'b0;
        end else if (w_adv && r_s1_close) begin
            r_out_valid <= 1'b1;
            r_best_cost <= w_n_cost;
            r_best_chg  <= w_n_found ? w_n_chg : CHG_NONE;
            r_best_pos  <= w_n_found ? w_n_pos : '0;
            r_found     <= w_n_found;
            r_grp_err   <= r_s1_err;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready    = w_en;
    assign out_valid   = r_out_valid;
    assign best_cost   = r_best_cost;
    assign best_change = r_best_chg;
    assign best_pos    = r_best_pos;
    assign found       = r_found;
    assign grp_err     = r_grp_err;

endmodule

// File: doc/sbh_cost_select.md
Name: sbh_cost_select

Overview:
- Multi-lane, group-level successor to the single-coefficient sign-bit-hiding cost evaluator.
- Accepts a coefficient group (CG) as a stream of beats, each beat carrying LANES coefficients with their deltaU and first-NZ flags.
- Computes a per-coefficient change cost, reduces across lanes and beats, and emits the minimum-cost position and change once per group.
- Sits between the RDOQ quantiser output and the SBH parity-adjust stage.

Parameters:
- COEFF_W, 16: coefficient and deltaU width, signed.
- LANES, 4: coefficients per beat. Power of 2, at least 1.
- CG_SIZE, 16: coefficients per group. Multiple of LANES.
- COST_W, 32: cost width, signed. Must be greater than COEFF_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  final beat of the group
- coef_in  in  LANES*COEFF_W  signed coefficients; lane i occupies bits [i*COEFF_W +: COEFF_W]
- deltaU_in  in  LANES*COEFF_W  signed rate-distortion delta per lane
- first_nz_in  in  LANES  lane holds the group's first nonzero coefficient
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  downstream accept
- best_cost  out  COST_W  minimum cost in the group
- best_change  out  2  signed change: +1, -1 or 0
- best_pos  out  $clog2(CG_SIZE)  position in group, computed as beat*LANES + lane
- found  out  1  at least one legal change exists in the group
- grp_err  out  1  group was closed by the beat limit, not by in_last

Behaviour:
- Reset values (rst_n low, asynchronous):
  - out_valid=0, found=0, grp_err=0, best_change=0, best_pos=0.
  - best_cost=INV, where INV=2^(COST_W-1)-1.
  - Beat counter and accumulator cleared; pipeline valids cleared.
- Global enable: en = !out_valid || out_ready.
  - in_ready = en.
  - All pipeline registers advance only when en=1; otherwise the whole pipeline stalls, including in-flight beats.
- Stage 1 (registered): per-lane cost. Let mag=|coef| and d=sign-extended deltaU.
  - d>0: cost=-d, change=+1. Applies to zero and nonzero coefficients.
  - d<0 and mag!=0 and !(first_nz && mag==1): cost=d, change=-1.
  - Otherwise: cost=INV, change=0.
  - -(-2^(COEFF_W-1)) is representable because COST_W > COEFF_W; no saturation is needed.
- Stage 2 (registered): lane reduction and running minimum.
  - Take the minimum cost across lanes; on a tie the lower lane wins.
  - Compare the beat winner with the accumulator.
    - Replace only if strictly smaller, so the earliest position wins ties.
    - On the first beat of a group, load the accumulator unconditionally.
- Beat counter:
  - Increments per accepted beat; wraps to 0 at group close.
  - Group closes on in_last, or when the counter reaches CG_SIZE/LANES-1.
  - Closing on the counter with in_last=0 sets grp_err=1 for that result.
  - Short groups (in_last before the limit) are legal; grp_err=0.
- Output register:
  - On the closing beat's stage-2 update, load best_*, set found = (cost!=INV), and assert out_valid.
  - Latency: out_valid asserts 2 enabled cycles after the last beat is accepted.
  - out_valid and all result fields hold stable while out_ready=0.
  - out_valid clears on accept unless a new result loads in the same cycle.
- Back-to-back groups: the next group's first beat may follow the previous group's last beat with no bubble.
- found=0 implies best_change=0, best_cost=INV, best_pos=0.
- Reset mid-group: the partial group is discarded; the next accepted beat is treated as beat 0.

Optional Feature:
- Macro SBH_CLAMP_MAX_EN.
- Defined: a lane with change=+1 and mag == 2^(COEFF_W-1)-1 is forced to cost=INV, change=0, so overflow is never proposed.
- Undefined: no clamp; +1 is permitted at maximum magnitude.

Test Plan:
- Lane rule check, LANES=4, one beat with in_last. coef={0,5,1,0}, deltaU={3,-7,-2,0}, first_nz={0,0,1,0}.
  -> lane costs {-3,-7,INV,INV}. Output best_pos=1, best_change=-1, best_cost=-7, found=1, grp_err=0.
- Tie across beats, 4 beats. Beat0 lane2 cost -4; beat3 lane0 cost -4; all other lanes INV.
  -> best_pos=2 (earliest position wins).
- No legal change: a full group with every deltaU=0.
  -> found=0, best_change=0, best_cost=0x7FFFFFFF, best_pos=0.
- Backpressure: hold out_ready=0 for 5 cycles while a second group streams in.
  -> in_ready=0 throughout; first result stable; second result follows 2 cycles after release with no lost beats.
- Missing last: 4 beats with in_last=0, then a new 1-beat group with in_last=1.
  -> first result grp_err=1; second result grp_err=0 with best_pos in 0..3.
- Extremes and reset: deltaU=-32768 on coef=3 -> best_cost=-32768, change=-1. Assert rst_n after 2 beats -> all outputs at reset values; the following group is evaluated from beat 0.
